// File: rtl/mm_pkg.sv
// Shared constants and state encoding for the matrix-multiply memory sequencer.
package mm_pkg;
  localparam int MAX_N     = 16;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int ACC_W     = 2 * DATA_W + $clog2(MAX_N);
  localparam int SAT_LIMIT = (1 << DATA_W) - 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    MAC,
    WR,
    FIN
  } state_e;
endpackage

// File: rtl/mm_mac.sv
// Dot-product accumulator with clear/enable and a saturated DATA_W-wide result.
module mm_mac #(
  parameter int DATA_W  = mm_pkg::DATA_W,
  parameter int ACC_W   = mm_pkg::ACC_W,
  parameter int SAT_MAX = mm_pkg::SAT_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              ovf
);
  import mm_pkg::*;

  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(a) * ACC_W'(b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign ovf = acc_q > ACC_W'(SAT_MAX);
  assign res = ovf ? DATA_W'(SAT_MAX) : acc_q[DATA_W-1:0];
endmodule

// File: rtl/matmul_mem_sequencer.sv
// Fetch/MAC/write-back sequencer computing C = A x B over a byte-wide memory.
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RD_A  | read A[i][k]
// RD_B  | read B[k][j]; capture A element returned by memory
// MAC   | accumulate a * B element returned by memory
// WR    | write saturated C[i][j], advance j then i
// FIN   | one-cycle done pulse
module matmul_mem_sequencer #(
  parameter int MAX_N  = mm_pkg::MAX_N,
  parameter int ADDR_W = mm_pkg::ADDR_W,
  parameter int DATA_W = mm_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        n,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sat,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_read_data
);
  import mm_pkg::*;

  localparam int ACC_W = 2 * DATA_W + $clog2(MAX_N);

  state_e            state_q, state_d;
  logic [4:0]        n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              err_q, err_d, sat_q, sat_d;
  logic              mac_clr, mac_en, mac_ovf;
  logic [DATA_W-1:0] mac_res;
  logic [4:0]        last_idx;
  logic [ADDR_W-1:0] n_ext, i_ext, j_ext, k_ext;

  assign last_idx = n_q - 5'd1;
  assign n_ext    = ADDR_W'(n_q);
  assign i_ext    = ADDR_W'(i_q);
  assign j_ext    = ADDR_W'(j_q);
  assign k_ext    = ADDR_W'(k_q);

  mm_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SAT_MAX((1 << DATA_W) - 1)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (a_q),
    .b    (mem_read_data),
    .res  (mac_res),
    .ovf  (mac_ovf)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    a_d      = a_q;
    err_d    = err_q;
    sat_d    = sat_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = n;
          base_a_d = base_a;
          base_b_d = base_b;
          base_c_d = base_c;
          a_d      = '0;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          mac_clr  = 1'b1;
          sat_d    = 1'b0;
          err_d    = int'(n) > MAX_N;
          state_d  = (n == 5'd0 || int'(n) > MAX_N) ? FIN : RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        a_d     = mem_read_data;
        state_d = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q != last_idx) begin
          k_d     = k_q + 5'd1;
          state_d = RD_A;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        mac_clr = 1'b1;
        k_d     = '0;
        if (mac_ovf) sat_d = 1'b1;
        if (j_q == last_idx) begin
          j_d = '0;
          if (i_q == last_idx) begin
            state_d = FIN;
          end else begin
            i_d     = i_q + 5'd1;
            state_d = RD_A;
          end
        end else begin
          j_d     = j_q + 5'd1;
          state_d = RD_A;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      a_q      <= '0;
      err_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      a_q      <= a_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
    end
  end

  // Outputs decode only registered state, so reset silences them immediately.
  always_comb begin
    busy           = (state_q == RD_A) || (state_q == RD_B) || (state_q == MAC) || (state_q == WR);
    done           = (state_q == FIN);
    mem_memread    = (state_q == RD_A) || (state_q == RD_B);
    mem_memwrite   = (state_q == WR);
    mem_write_data = (state_q == WR) ? mac_res : '0;
    case (state_q)
      RD_A:    mem_address = base_a_q + i_ext * n_ext + k_ext;
      RD_B:    mem_address = base_b_q + k_ext * n_ext + j_ext;
      WR:      mem_address = base_c_q + i_ext * n_ext + j_ext;
      default: mem_address = '0;
    endcase
  end

  assign err = err_q;
  assign sat = sat_q;
endmodule

// File: tb/tb_matmul_mem_sequencer.sv
// Self-checking bench: byte memory model plus a per-cycle expected-output trace built from matrix arithmetic.
module tb_matmul_mem_sequencer;
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd;
    logic        wr;
    logic        err;
    logic        sat;
    logic [15:0] addr;
    logic [7:0]  wd;
  } vec_t;

  logic        clk, rst_n, start;
  logic [4:0]  n;
  logic [15:0] base_a, base_b, base_c;
  logic        busy, done, err, sat;
  logic [15:0] mem_address;
  logic [7:0]  mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread;

  logic [7:0]  mem [0:65535];
  int          a_m [0:255];
  int          b_m [0:255];
  int          c_exp [0:255];
  vec_t        exp_q [$];
  logic        m_err, m_sat, chk_en;
  int          errors, checks, done_seen, busy_seen, job_done0, job_n, nprint;
  logic [15:0] job_bc;

  matmul_mem_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .n             (n),
    .base_a        (base_a),
    .base_b        (base_b),
    .base_c        (base_c),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .sat           (sat),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_memwrite  (mem_memwrite),
    .mem_memread   (mem_memread),
    .mem_read_data (mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte memory with registered read (1-cycle latency)
  initial mem_read_data = 8'h00;
  always @(posedge clk) begin
    if (mem_memwrite) mem[mem_address] = mem_write_data;
    if (mem_memread) mem_read_data <= mem[mem_address];
  end

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input bit b, input bit d, input bit r, input bit w,
                              input bit e, input bit s, input logic [15:0] a, input logic [7:0] wd);
    vec_t v;
    v.busy = b; v.done = d; v.rd = r; v.wr = w; v.err = e; v.sat = s; v.addr = a; v.wd = wd;
    return v;
  endfunction

  // Per-cycle compare against the expected trace (idle vector when the trace is empty)
  initial begin
    vec_t act, ex;
    logic prev_wr, prev_busy, prev_done;
    prev_wr = 0; prev_busy = 0; prev_done = 0;
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        act = {busy, done, mem_memread, mem_memwrite, err, sat, mem_address, mem_write_data};
        if (exp_q.size() > 0) ex = exp_q.pop_front();
        else ex = mk(0, 0, 0, 0, m_err, m_sat, 16'h0, 8'h0);
        checks++;
        if (act !== ex) begin
          errors++;
          if (nprint < 20) $display("FAIL cycle_vec t=%0t got %h expected %h", $time, act, ex);
          nprint++;
        end
        checks++;
        if (mem_memread && mem_memwrite) begin
          errors++;
          $display("FAIL rd_wr_exclusive t=%0t got rd=1 wr=1 expected not both", $time);
        end
        if (done) begin
          checks++;
          if (!(prev_wr || (!prev_busy && !prev_done))) begin
            errors++;
            $display("FAIL done_origin t=%0t got done after busy=%0d wr=%0d expected after WR or idle",
                     $time, prev_busy, prev_wr);
          end
          done_seen++;
        end
        if (busy) busy_seen++;
        prev_wr = mem_memwrite; prev_busy = busy; prev_done = done;
      end else begin
        prev_wr = 0; prev_busy = 0; prev_done = 0;
      end
    end
  end

  task automatic launch(input int nn, input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc);
    int   acc, c;
    logic s, e;
    job_n  = nn;
    job_bc = bc;
    if (nn >= 1 && nn <= 16) begin
      for (int r = 0; r < nn; r++)
        for (int q = 0; q < nn; q++) begin
          mem[ba + 16'(r * nn + q)] = 8'(a_m[r * nn + q]);
          mem[bb + 16'(r * nn + q)] = 8'(b_m[r * nn + q]);
          mem[bc + 16'(r * nn + q)] = 8'h00;
        end
    end
    @(negedge clk);
    start = 1; n = 5'(nn); base_a = ba; base_b = bb; base_c = bc;
    e = (nn > 16);
    s = 0;
    job_done0 = done_seen;
    if (nn == 0 || nn > 16) begin
      exp_q.push_back(mk(0, 1, 0, 0, e, 0, 16'h0, 8'h0));
    end else begin
      for (int i = 0; i < nn; i++)
        for (int j = 0; j < nn; j++) begin
          acc = 0;
          for (int k = 0; k < nn; k++) begin
            exp_q.push_back(mk(1, 0, 1, 0, 0, s, ba + 16'(i * nn + k), 8'h0));
            exp_q.push_back(mk(1, 0, 1, 0, 0, s, bb + 16'(k * nn + j), 8'h0));
            exp_q.push_back(mk(1, 0, 0, 0, 0, s, 16'h0, 8'h0));
            acc += a_m[i * nn + k] * b_m[k * nn + j];
          end
          c = (acc > 255) ? 255 : acc;
          c_exp[i * nn + j] = c;
          exp_q.push_back(mk(1, 0, 0, 1, 0, s, bc + 16'(i * nn + j), 8'(c)));
          if (acc > 255) s = 1;
        end
      exp_q.push_back(mk(0, 1, 0, 0, 0, s, 16'h0, 8'h0));
    end
    m_err = e;
    m_sat = s;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    #3;
    check("trace_drained", exp_q.size(), 0);
    check("done_pulses", done_seen - job_done0, 1);
    if (job_n >= 1 && job_n <= 16)
      for (int x = 0; x < job_n * job_n; x++)
        check($sformatf("c[%0d]", x), int'(mem[job_bc + 16'(x)]), c_exp[x]);
  endtask

  task automatic load_2x2();
    a_m[0] = 1; a_m[1] = 2; a_m[2] = 3; a_m[3] = 4;
    b_m[0] = 5; b_m[1] = 6; b_m[2] = 7; b_m[3] = 8;
  endtask

  task automatic check_2x2(input string nm, input logic [15:0] bc);
    check({nm, "_c0"}, int'(mem[bc]), 19);
    check({nm, "_c1"}, int'(mem[bc + 16'd1]), 22);
    check({nm, "_c2"}, int'(mem[bc + 16'd2]), 43);
    check({nm, "_c3"}, int'(mem[bc + 16'd3]), 50);
  endtask

  initial begin
    int nn, hi;
    logic [15:0] ba;
    errors = 0; checks = 0; done_seen = 0; busy_seen = 0; nprint = 0;
    m_err = 0; m_sat = 0; chk_en = 0;
    rst_n = 0; start = 0; n = 0; base_a = 0; base_b = 0; base_c = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({busy, done, err, sat, mem_memread, mem_memwrite, mem_address, mem_write_data}), 0);
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    load_2x2();
    busy_seen = 0;
    launch(2, 16'h0000, 16'h0010, 16'h0020);
    wait_done();
    check_2x2("basic", 16'h0020);
    check("basic_busy_cycles", busy_seen, 28);
    check("basic_sat", int'(sat), 0);

    a_m[0] = 20; b_m[0] = 20;
    launch(1, 16'h0300, 16'h0301, 16'h0302);
    wait_done();
    check("sat_c", int'(mem[16'h0302]), 255);
    check("sat_flag", int'(sat), 1);
    a_m[0] = 2; b_m[0] = 2;
    launch(1, 16'h0300, 16'h0301, 16'h0302);
    wait_done();
    check("unsat_c", int'(mem[16'h0302]), 4);
    check("sat_cleared", int'(sat), 0);

    busy_seen = 0;
    launch(0, 16'h0000, 16'h0010, 16'h0020);
    wait_done();
    check("n0_err", int'(err), 0);
    launch(17, 16'h0000, 16'h0010, 16'h0020);
    wait_done();
    check("n17_err", int'(err), 1);
    check("degenerate_busy_cycles", busy_seen, 0);

    load_2x2();
    launch(2, 16'h0100, 16'hFFFF, 16'h0200);
    wait_done();
    check_2x2("wrap", 16'h0200);
    check("err_cleared", int'(err), 0);

    // start pulse while busy must be ignored
    load_2x2();
    for (int x = 0; x < 4; x++) mem[16'h0020 + 16'(x)] = 8'h00;
    launch(2, 16'h0000, 16'h0010, 16'h0020);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1; n = 5'd3; base_a = 16'h0500; base_b = 16'h0600; base_c = 16'h0700;
    @(posedge clk);
    #1 start = 0;
    wait_done();
    check_2x2("ignored_start", 16'h0020);

    // asynchronous reset mid-run
    for (int x = 0; x < 9; x++) begin a_m[x] = $urandom_range(0, 255); b_m[x] = $urandom_range(0, 255); end
    launch(3, 16'h0800, 16'h0900, 16'h0A00);
    repeat (12) @(posedge clk);
    #3;
    rst_n = 0;
    chk_en = 0;
    #1;
    check("midrun_reset_outputs", int'({busy, done, err, sat, mem_memread, mem_memwrite, mem_address, mem_write_data}), 0);
    exp_q.delete();
    m_err = 0; m_sat = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_en = 1;
    load_2x2();
    for (int x = 0; x < 4; x++) mem[16'h0020 + 16'(x)] = 8'h00;
    launch(2, 16'h0000, 16'h0010, 16'h0020);
    wait_done();
    check_2x2("after_reset", 16'h0020);

    // randomized jobs
    for (int t = 0; t < 9; t++) begin
      nn = (t == 8) ? 16 : $urandom_range(1, 6);
      hi = (t == 8) ? 3 : ((t % 2 == 0) ? 255 : 7);
      for (int x = 0; x < nn * nn; x++) begin
        a_m[x] = $urandom_range(0, hi);
        b_m[x] = $urandom_range(0, hi);
      end
      ba = 16'($urandom);
      launch(nn, ba, ba + 16'h0400, ba + 16'h0800);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
